// File: rtl/router_alloc_ctrl.sv
// router_alloc_ctrl: 5-port NoC switch allocator with single-flit input slots, XY-wrap routing and round-robin output arbitration
module router_alloc_ctrl #(
  parameter int          WIDTH_PACKAGE = 33,
  parameter logic [3:0]  ROUTER_LOC    = 4'b01_01
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [4:0]                 in_valid_i,
  output logic [4:0]                 in_ready_o,
  input  logic [5*WIDTH_PACKAGE-1:0] in_data_i,
  output logic [4:0]                 out_valid_o,
  input  logic [4:0]                 out_ready_i,
  output logic [5*WIDTH_PACKAGE-1:0] out_data_o,
  output logic [14:0]                out_src_o
);
  localparam int         W       = WIDTH_PACKAGE;
  localparam logic [2:0] P_LEFT  = 3'd0;
  localparam logic [2:0] P_RIGHT = 3'd1;
  localparam logic [2:0] P_UP    = 3'd2;
  localparam logic [2:0] P_DOWN  = 3'd3;
  localparam logic [2:0] P_PE    = 3'd4;
  localparam logic       ST_EMPTY = 1'b0;
  localparam logic       ST_HELD  = 1'b1;

  logic [4:0]   state_q;
  logic [W-1:0] slot_data_q  [5];
  logic [2:0]   slot_route_q [5];
  logic [4:0]   out_valid_q;
  logic [W-1:0] out_data_q   [5];
  logic [2:0]   out_src_q    [5];
  logic [2:0]   rr_q         [5];
  logic [4:0]   can_load;
  logic [4:0]   grant;
  logic [4:0]   freed;
  logic [2:0]   win          [5];
  logic [2:0]   idx;

  // Destinations 13..15 fold onto node 0; both axes use 2-bit wrap distance
  function automatic logic [2:0] route(input logic [3:0] d);
    logic [1:0] xd, yd, dx, dy;
    xd = d > 4'd12 ? 2'd0 : d[1:0];
    yd = d > 4'd12 ? 2'd0 : d[3:2];
    dx = xd - ROUTER_LOC[3:2];
    dy = yd - ROUTER_LOC[1:0];
    return dx == 2'd1 ? P_RIGHT : dx != 2'd0 ? P_LEFT :
           dy == 2'd1 ? P_UP : dy != 2'd0 ? P_DOWN : P_PE;
  endfunction

  function automatic logic [2:0] wrap5(input logic [2:0] p, input int k);
    logic [3:0] s;
    s = {1'b0, p} + 4'(k);
    return s >= 4'd5 ? 3'(s - 4'd5) : s[2:0];
  endfunction

  assign can_load    = ~out_valid_q | out_ready_i;
  assign in_ready_o  = ~state_q;
  assign out_valid_o = out_valid_q;

  // Round-robin pick per output; scanning from farthest to nearest leaves the nearest requester as winner
  always_comb begin
    grant = '0;
    freed = '0;
    idx   = '0;
    for (int o = 0; o < 5; o++) begin
      win[o] = '0;
      for (int k = 5; k >= 1; k--) begin
        idx = wrap5(rr_q[o], k);
        if (state_q[idx] == ST_HELD && slot_route_q[idx] == 3'(o)) begin
          grant[o] = can_load[o];
          win[o]   = idx;
        end
      end
    end
    for (int i = 0; i < 5; i++)
      for (int o = 0; o < 5; o++)
        if (grant[o] && win[o] == 3'(i)) freed[i] = 1'b1;
  end

  // Flatten per-port output registers onto the packed buses
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      out_data_o[p*W +: W] = out_data_q[p];
      out_src_o[p*3 +: 3]  = out_src_q[p];
    end
  end

  // Input slots: capture flit and its route when empty, release on grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '0;
      for (int p = 0; p < 5; p++) begin
        slot_data_q[p]  <= '0;
        slot_route_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (state_q[p] == ST_EMPTY && in_valid_i[p]) begin
          state_q[p]      <= ST_HELD;
          slot_data_q[p]  <= in_data_i[p*W +: W];
          slot_route_q[p] <= route(in_data_i[p*W+W-4 +: 4]);
        end else if (freed[p]) begin
          state_q[p] <= ST_EMPTY;
        end
      end
    end
  end

  // Output stage: load winner, or retire the current flit when drained with nothing pending
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= '0;
      for (int o = 0; o < 5; o++) begin
        out_data_q[o] <= '0;
        out_src_q[o]  <= '0;
        rr_q[o]       <= 3'd4;
      end
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (grant[o]) begin
          out_valid_q[o] <= 1'b1;
          out_data_q[o]  <= slot_data_q[win[o]];
          out_src_q[o]   <= win[o];
          rr_q[o]        <= win[o];
        end else if (out_ready_i[o]) begin
          out_valid_q[o] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_router_alloc_ctrl.sv
// tb_router_alloc_ctrl: directed checks of routing, arbitration, backpressure and reset
module tb_router_alloc_ctrl;
  localparam int W = 33;
  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [4:0]       in_valid = '0;
  logic [4:0]       in_ready;
  logic [5*W-1:0]   in_data = '0;
  logic [4:0]       out_valid;
  logic [4:0]       out_ready = 5'b11111;
  logic [5*W-1:0]   out_data;
  logic [14:0]      out_src;
  int               n_chk = 0;
  int               n_err = 0;

  router_alloc_ctrl #(.WIDTH_PACKAGE(W), .ROUTER_LOC(4'b0101)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_src_o(out_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] flit(input logic [3:0] d, input logic [28:0] p);
    return {d, p};
  endfunction

  task automatic drive(input int i, input logic [3:0] d, input logic [28:0] p);
    in_valid[i] = 1'b1;
    in_data[i*W +: W] = flit(d, p);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [3:0] t2_dest [8] = '{4'd5, 4'd4, 4'd6, 4'd7, 4'd1, 4'd9, 4'd13, 4'd15};
  int         t2_port [8] = '{4, 0, 1, 0, 3, 2, 0, 0};

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'h1f);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_src", 64'(out_src), 64'h0);
    chk("rst_out_data_pe", 64'(out_data[4*W +: W]), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: PE -> dest 6 -> RIGHT
    drive(4, 4'd6, 29'h123);
    tick();
    in_valid = '0;
    chk("t1_in_ready_held", 64'(in_ready[4]), 64'h0);
    chk("t1_not_yet", 64'(out_valid), 64'h0);
    tick();
    chk("t1_valid", 64'(out_valid), 64'h02);
    chk("t1_src", 64'(out_src[3 +: 3]), 64'd4);
    chk("t1_data", 64'(out_data[W +: W]), 64'(flit(4'd6, 29'h123)));
    tick();
    chk("t1_drop", 64'(out_valid), 64'h0);

    // T2: route sweep from input 0
    for (int k = 0; k < 8; k++) begin
      drive(0, t2_dest[k], 29'(32'h100 + k));
      tick();
      in_valid = '0;
      tick();
      chk($sformatf("t2_valid_d%0d", t2_dest[k]), 64'(out_valid), 64'(5'b1 << t2_port[k]));
      chk($sformatf("t2_src_d%0d", t2_dest[k]), 64'(out_src[t2_port[k]*3 +: 3]), 64'd0);
      chk($sformatf("t2_data_d%0d", t2_dest[k]), 64'(out_data[t2_port[k]*W +: W]),
          64'(flit(t2_dest[k], 29'(32'h100 + k))));
      tick();
    end

    // T3: inputs 0..2 stream to PE, fair rotation
    do_reset();
    for (int i = 0; i < 3; i++) drive(i, 4'd5, 29'(i + 16));
    tick();
    for (int n = 0; n < 9; n++) begin
      tick();
      chk($sformatf("t3_valid_%0d", n), 64'(out_valid[4]), 64'h1);
      chk($sformatf("t3_src_%0d", n), 64'(out_src[12 +: 3]), 64'(n % 3));
      chk($sformatf("t3_data_%0d", n), 64'(out_data[4*W +: W]), 64'(flit(4'd5, 29'((n % 3) + 16))));
    end
    in_valid = '0;
    repeat (5) tick();
    chk("t3_drained", 64'(out_valid), 64'h0);

    // T4: DOWN backpressure with two flits from input 3
    out_ready = 5'b10111;
    drive(3, 4'd1, 29'hA);
    tick();
    in_data[3*W +: W] = flit(4'd1, 29'hB);
    tick();
    chk("t4_a_valid", 64'(out_valid[3]), 64'h1);
    chk("t4_a_data", 64'(out_data[3*W +: W]), 64'(flit(4'd1, 29'hA)));
    chk("t4_b_not_taken_same_edge", 64'(in_ready[3]), 64'h1);
    tick();
    in_valid = '0;
    chk("t4_b_held", 64'(in_ready[3]), 64'h0);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("t4_stable_%0d", n), 64'(out_data[3*W +: W]), 64'(flit(4'd1, 29'hA)));
      chk($sformatf("t4_blocked_%0d", n), 64'(in_ready[3]), 64'h0);
    end
    out_ready = 5'b11111;
    tick();
    chk("t4_b_valid", 64'(out_valid[3]), 64'h1);
    chk("t4_b_data", 64'(out_data[3*W +: W]), 64'(flit(4'd1, 29'hB)));
    tick();
    chk("t4_empty", 64'(out_valid[3]), 64'h0);
    chk("t4_slot_free", 64'(in_ready[3]), 64'h1);

    // T5: five inputs to five distinct outputs
    drive(0, 4'd5, 29'h50);
    drive(1, 4'd4, 29'h51);
    drive(2, 4'd6, 29'h52);
    drive(3, 4'd9, 29'h53);
    drive(4, 4'd1, 29'h54);
    tick();
    in_valid = '0;
    chk("t5_none_yet", 64'(out_valid), 64'h0);
    tick();
    chk("t5_all_valid", 64'(out_valid), 64'h1f);
    chk("t5_srcs", 64'(out_src), 64'(15'b000_100_011_010_001));
    chk("t5_up_data", 64'(out_data[2*W +: W]), 64'(flit(4'd9, 29'h53)));
    tick();

    // T6: reset mid-transfer, then lowest-index requester wins first
    out_ready = '0;
    for (int i = 0; i < 5; i++) drive(i, 4'd5, 29'(i));
    tick();
    in_valid = '0;
    tick();
    chk("t6_pe_loaded", 64'(out_valid), 64'h10);
    chk("t6_pe_rr_src", 64'(out_src[12 +: 3]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'h0);
    chk("t6_rst_ready", 64'(in_ready), 64'h1f);
    chk("t6_rst_src", 64'(out_src), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 5'b11111;
    drive(1, 4'd5, 29'h61);
    drive(3, 4'd5, 29'h63);
    drive(2, 4'd4, 29'h62);
    drive(4, 4'd4, 29'h64);
    tick();
    in_valid = '0;
    tick();
    chk("t6_pe_first", 64'(out_src[12 +: 3]), 64'd1);
    chk("t6_left_first", 64'(out_src[0 +: 3]), 64'd2);
    tick();
    chk("t6_pe_second", 64'(out_src[12 +: 3]), 64'd3);
    chk("t6_left_second", 64'(out_src[0 +: 3]), 64'd4);
    chk("t6_left_data", 64'(out_data[0 +: W]), 64'(flit(4'd4, 29'h64)));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
